// File: rtl/mul_acc_pkg.sv
// Shared types and constants for the multiply-accumulate frame block.
// Holds the FSM state encoding and the width/range of the incoming products.
package mul_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int PRODUCT_W   = 5;
    localparam int PRODUCT_MAX = 21;

endpackage

// File: rtl/mul_acc_term_counter.sv
// Counts accepted products within a frame; o_last flags the final term slot.
// Clear takes priority over increment so a last accept wraps straight to zero.
module mul_acc_term_counter #(
    parameter int TERMS = 4
) (
    input  logic i_clk,
    input  logic i_inc,
    input  logic i_clear,
    output logic o_last
);

    localparam int CW = $clog2(TERMS + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_last = (r_count == CW'(TERMS - 1));

endmodule

// File: rtl/mul_acc_frame.sv
// Sums TERMS products into a frame result and holds it on an output handshake.
// Build option MUL_ACC_FRAME_SATURATE_EN: saturate acc and raise sticky ovf instead of wrapping.
module mul_acc_frame
    import mul_acc_pkg::*;
#(
    parameter int TERMS = 4,
    parameter int ACC_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRODUCT_W-1:0] p,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    output logic [ACC_W-1:0]     acc,
    output logic                 ovf
);

    state_t           r_state;
    state_t           w_nextState;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_accNext;
    logic [ACC_W-1:0] w_accSum;
    logic             r_accValid;
    logic             w_accValidNext;
    logic             w_accept;
    logic             w_abort;
    logic             w_handoff;
    logic             w_last;
    logic             w_cntClear;

    assign in_ready  = (r_state == ACCUM) && !clr && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_abort   = (r_state == ACCUM) && clr;
    assign w_handoff = (r_state == HOLD) && r_accValid && acc_ready;

    // A finished frame also clears the count, so HOLD always starts the next frame at zero.
    assign w_cntClear = rst || w_abort || (w_accept && w_last);

    mul_acc_term_counter #(
        .TERMS (TERMS)
    ) u_termCounter (
        .i_clk   (clk),
        .i_inc   (w_accept),
        .i_clear (w_cntClear),
        .o_last  (w_last)
    );

`ifdef MUL_ACC_FRAME_SATURATE_EN
    logic [ACC_W:0] w_sum;
    logic           r_ovf;
    logic           w_ovfNext;

    // One extra sum bit exposes the carry that signals overflow.
    assign w_sum    = {1'b0, r_acc} + (ACC_W + 1)'(p);
    assign w_accSum = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];

    always_comb begin
        w_ovfNext = r_ovf;
        if (w_abort || w_handoff) begin
            w_ovfNext = 1'b0;
        end else if (w_accept) begin
            w_ovfNext = r_ovf | w_sum[ACC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovfNext;
        end
    end

    assign ovf = r_ovf;
`else
    assign w_accSum = r_acc + ACC_W'(p);
    assign ovf      = 1'b0;
`endif

    always_comb begin
        w_nextState    = r_state;
        w_accNext      = r_acc;
        w_accValidNext = r_accValid;
        case (r_state)
            ACCUM: begin
                if (w_abort) begin
                    w_accNext = '0;
                end else if (w_accept) begin
                    w_accNext = w_accSum;
                    if (w_last) begin
                        w_nextState    = HOLD;
                        w_accValidNext = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (w_handoff) begin
                    w_nextState    = ACCUM;
                    w_accNext      = '0;
                    w_accValidNext = 1'b0;
                end
            end
            default: begin
                w_nextState = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ACCUM;
            r_acc      <= '0;
            r_accValid <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_acc      <= w_accNext;
            r_accValid <= w_accValidNext;
        end
    end

    assign acc       = r_acc;
    assign acc_valid = r_accValid;

endmodule
